// File: rtl/dualmem_port_arbiter.sv
// Round-robin arbiter sharing one port of the 2048x64 byte-writable scratch RAM between two requesters.
// Optional per-requester/conflict performance counters are built when DUALMEM_ARB_PERF_EN is defined.
module dualmem_port_arbiter #(
  parameter int AW   = 11,
  parameter int DW   = 64,
  parameter int NREQ = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ-1:0]                we_i,
  input  logic [NREQ-1:0][DW/8-1:0]      be_i,
  input  logic [NREQ-1:0][AW-1:0]        addr_i,
  input  logic [NREQ-1:0][DW-1:0]        wdata_i,
  output logic [NREQ-1:0]                gnt_o,
  output logic [NREQ-1:0]                rvalid_o,
  output logic [DW-1:0]                  rdata_o,
  output logic [DW/8-1:0]                mem_en_o,
  output logic [DW/8-1:0]                mem_we_o,
  output logic [AW-1:0]                  mem_addr_o,
  output logic [DW-1:0]                  mem_wdata_o,
  input  logic [DW-1:0]                  mem_rdata_i
`ifdef DUALMEM_ARB_PERF_EN
  ,
  input  logic                           perf_clr_i,
  output logic [31:0]                    perf_gnt0_o,
  output logic [31:0]                    perf_gnt1_o,
  output logic [31:0]                    perf_conflict_o
`endif
);

  // Handshake: a requester holds req/we/be/addr/wdata stable until the cycle
  // where req_i[n] & gnt_o[n]; that cycle is the accept. Reads return rvalid_o[n]
  // for exactly one cycle, one cycle after the accept; writes have no response.

  logic last;     // index granted most recently; 1 out of reset so requester 0 wins first
  logic accept;
  logic win;

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  assign accept = |gnt_o;
  assign win    = gnt_o[1];

  // A write with be=0 still drives en=0, so the slot is used but nothing changes.
  always_comb begin
    mem_en_o    = '0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (accept) begin
      mem_addr_o  = addr_i[win];
      mem_wdata_o = wdata_i[win];
      if (we_i[win]) begin
        mem_en_o = be_i[win];
        mem_we_o = be_i[win];
      end else begin
        mem_en_o = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last     <= 1'b1;
      rvalid_o <= '0;
    end else begin
      if (accept) last <= win;
      rvalid_o <= gnt_o & ~we_i;
    end
  end

  // The RAM registers its output, so the data lines up with rvalid_o as-is.
  assign rdata_o = mem_rdata_i;

`ifdef DUALMEM_ARB_PERF_EN
  logic [31:0] cnt_gnt0;
  logic [31:0] cnt_gnt1;
  logic [31:0] cnt_conflict;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else if (perf_clr_i) begin
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else begin
      if (gnt_o[0] && (cnt_gnt0 != 32'hFFFF_FFFF)) cnt_gnt0 <= cnt_gnt0 + 32'd1;
      if (gnt_o[1] && (cnt_gnt1 != 32'hFFFF_FFFF)) cnt_gnt1 <= cnt_gnt1 + 32'd1;
      if ((req_i == 2'b11) && (cnt_conflict != 32'hFFFF_FFFF))
        cnt_conflict <= cnt_conflict + 32'd1;
    end
  end

  assign perf_gnt0_o     = cnt_gnt0;
  assign perf_gnt1_o     = cnt_gnt1;
  assign perf_conflict_o = cnt_conflict;
`endif

endmodule
